// File: rtl/op2_pkg.sv
// Shared definitions for the two-operand add/multiply datapath: control-word
// bit positions, canonical microinstructions and the RR input-mux decode.
package op2_pkg;

    localparam int Y_LDA  = 1;   // RA <= da
    localparam int Y_LDB  = 2;   // RB <= db
    localparam int Y_SHF  = 3;   // shift {RR,RB,RBE}
    localparam int Y_ADA  = 4;   // adder right operand = RA
    localparam int Y_SUBA = 5;   // adder right operand = ~RA (+1 when multiplying)
    localparam int Y_SUM  = 6;   // RR mux selects adder
    localparam int Y_WRR  = 7;   // RR write enable
    localparam int Y_CLR  = 8;   // RR mux selects zero
    localparam int Y_RRL  = 9;   // adder left operand = RR
    localparam int Y_RPR  = 10;  // RPR <= flags of RR

    typedef logic [10:1] ctrl_t;

    localparam ctrl_t INIT    = 10'b0011000111;
    localparam ctrl_t ADD_AB  = 10'b0001101000;
    localparam ctrl_t ADD_RA  = 10'b0101101000;
    localparam ctrl_t SUB_RA  = 10'b0101110000;
    localparam ctrl_t PASS_RR = 10'b0101100000;
    localparam ctrl_t SHIFT   = 10'b0001000100;
    localparam ctrl_t CLR_RR  = 10'b0011000000;
    localparam ctrl_t WR_RPR  = 10'b1000000000;

    typedef enum logic [1:0] {RR_HOLD, RR_ZERO, RR_SUM, RR_SHIFT} rr_sel_e;

    // Zero beats sum beats shift; a load of RB alongside y3 suppresses the shift.
    function automatic rr_sel_e rr_sel(input ctrl_t y);
        if (!y[Y_WRR])                 return RR_HOLD;
        if (y[Y_CLR])                  return RR_ZERO;
        if (y[Y_SUM])                  return RR_SUM;
        if (y[Y_SHF] && !y[Y_LDB])     return RR_SHIFT;
        return RR_HOLD;
    endfunction

endpackage

// File: rtl/op2_adder.sv
// N+1 bit adder: two's complement with carry-in when cop=1, ones' complement
// with end-around carry over the low N bits when cop=0.
module op2_adder #(
    parameter int N = 4
) (
    input  logic         cop,
    input  logic [N:0]   lop,
    input  logic [N-1:0] ra,
    input  logic         add_ra,
    input  logic         sub_ra,
    output logic [N:0]   sum
);

    logic [N:0]   rop;
    logic [N:0]   raw;
    logic [N-1:0] eac;

    always_comb begin
        rop = '0;
        if (sub_ra)
            rop = ~{ra[N-1], ra};
        else if (add_ra)
            rop = {ra[N-1], ra};
    end

    // Ones' complement: carry out of bit N-1 wraps back into bit 0.
    assign raw = {1'b0, lop[N-1:0]} + {1'b0, rop[N-1:0]};
    assign eac = raw[N-1:0] + {{(N-1){1'b0}}, raw[N]};

    assign sum = cop ? (lop + rop + {{N{1'b0}}, sub_ra}) : {eac[N-1], eac};

endmodule

// File: rtl/op_block_2oper.sv
// Operation block executing control word y[10:1] for the add/Booth-multiply unit.
// Define OVF_DETECT_EN to widen rpr to {ovf,sign,zero}.
module op_block_2oper
    import op2_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         set_n,
    input  logic         cop,
    input  logic [N-1:0] da,
    input  logic [N-1:0] db,
    input  logic [10:1]  y,
    output logic [2:0]   x,
`ifdef OVF_DETECT_EN
    output logic [2:0]   rpr,
`else
    output logic [1:0]   rpr,
`endif
    output logic [2*N-1:0] res
);

    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N:0]   rr;     // bit N is the guard bit
    logic         rbe;
    logic [N:0]   lop;
    logic [N:0]   sum;

    assign lop = y[Y_RRL] ? rr : {rb[N-1], rb};

    op2_adder #(.N(N)) u_adder (
        .cop    (cop),
        .lop    (lop),
        .ra     (ra),
        .add_ra (y[Y_ADA]),
        .sub_ra (y[Y_SUBA]),
        .sum    (sum)
    );

    always_ff @(posedge clk) begin
        if (!set_n) begin
            ra  <= '0;
            rb  <= '0;
            rr  <= '0;
            rbe <= 1'b0;
            rpr <= '0;
        end else begin
            if (y[Y_LDA])
                ra <= da;

            if (y[Y_LDB]) begin
                rb <= db;
                if (y[Y_SHF])
                    rbe <= 1'b0;
            end else if (y[Y_SHF]) begin
                rb  <= {rr[0], rb[N-1:1]};
                rbe <= rb[0];
            end

            case (rr_sel(y))
                RR_ZERO:  rr <= '0;
                RR_SUM:   rr <= sum;
                RR_SHIFT: rr <= {rr[N], rr[N:1]};
                default:  rr <= rr;
            endcase

            // Flags sample RR before any write in the same cycle.
            if (y[Y_RPR]) begin
`ifdef OVF_DETECT_EN
                rpr <= {rr[N] ^ rr[N-1], rr[N-1], ~|rr[N-1:0]};
`else
                rpr <= {rr[N-1], ~|rr[N-1:0]};
`endif
            end
        end
    end

    assign x   = {~cop & (&rr[N-1:0]), rbe, rb[0]};
    assign res = {rr[N-1:0], rb};

endmodule
